// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared constants, auth state type and A2D helpers for segway
package segway_pkg;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic [1:0] {
    AUTH_OFF  = 2'd0,
    AUTH_PWR1 = 2'd1,
    AUTH_PWR2 = 2'd2
  } auth_state_t;

  localparam logic [2:0] CH_LFT  = 3'd0;
  localparam logic [2:0] CH_RGHT = 3'd4;
  localparam logic [2:0] CH_BATT = 3'd5;

  localparam logic [11:0] DEF_MIN_RIDER_WT = 12'h200;
  localparam logic [11:0] DEF_BATT_LOW     = 12'h800;

  // Round-robin slot to ADC128S channel number
  function automatic logic [2:0] ch_of_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    return CH_LFT;
      2'd1:    return CH_RGHT;
      default: return CH_BATT;
    endcase
  endfunction

  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/segway_uart_rx.sv
// rtl/segway_uart_rx.sv - 8N1 UART receiver, LSB first, centre-sampled
module segway_uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_clr_rdy,
  output logic       o_rdy,
  output logic [7:0] o_data
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // [1:0] synchroniser, [2] one-clock history for start-edge detection
  logic [2:0]    r_rx_sync;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_rdy;
  logic [7:0]    r_data;
  logic          w_rx;
  logic          w_fall;

  assign w_rx   = r_rx_sync[1];
  assign w_fall = r_rx_sync[2] & ~r_rx_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_sync <= 3'b111;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rdy     <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[1:0], i_rx};
      if (i_clr_rdy) r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_rdy   <= 1'b0;
            r_cnt   <= HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            // A start bit that is high again at its centre was a glitch
            r_state <= w_rx ? S_IDLE : S_DATA;
            r_cnt   <= FULL;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= FULL;
            if (r_bit == 3'd7) r_state <= S_STOP;
            r_bit <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            r_data  <= r_shift;
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign o_rdy  = r_rdy;
  assign o_data = r_data;

endmodule

// File: rtl/segway.sv
// rtl/segway.sv - power-up supervisor: BLE auth FSM, A2D load-cell/battery poller, piezo alarm
module segway
  import segway_pkg::*;
#(
  parameter int          BAUD_DIV     = 2604,
  parameter logic [11:0] MIN_RIDER_WT = DEF_MIN_RIDER_WT,
  parameter logic [11:0] BATT_LOW     = DEF_BATT_LOW,
  parameter int          FAST_SIM     = 0
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       RX,
  output logic       A2D_SS_n,
  output logic       A2D_SCLK,
  output logic       A2D_MOSI,
  input  logic       A2D_MISO,
  output logic       INERT_SS_n,
  output logic       INERT_SCLK,
  output logic       INERT_MOSI,
  input  logic       INERT_MISO,
  input  logic       INT,
  output logic       PWM_frwrd_lft,
  output logic       PWM_rev_lft,
  output logic       PWM_frwrd_rght,
  output logic       PWM_rev_rght,
  output logic       piezo,
  output logic       piezo_n,
  output logic [7:0] LED
);

  localparam logic [15:0] POLL_MASK = (FAST_SIM != 0) ? 16'h00FF : 16'hFFFF;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_XFER = 3'd1;
  localparam logic [2:0] P_HOLD = 3'd2;
  localparam logic [2:0] P_GAP  = 3'd3;

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic        w_rx_rdy;
  logic [7:0]  w_rx_data;
  logic        w_clr_rx_rdy;
  auth_state_t r_state;
  auth_state_t w_state_nxt;
  logic        r_pwr_up;
  logic [15:0] r_poll_cnt;
  logic        w_poll_tick;
  logic [2:0]  r_pst;
  logic [4:0]  r_ph;
  logic [3:0]  r_bit;
  logic        r_txn;
  logic [1:0]  r_ch_idx;
  logic [2:0]  w_ch;
  logic        r_ss_n;
  logic        r_sclk;
  logic        r_mosi;
  logic [15:0] r_tx;
  logic [15:0] r_rx;
  logic [11:0] r_lft;
  logic [11:0] r_rght;
  logic [11:0] r_batt;
  logic [12:0] w_load_sum;
  logic        w_rider_off;
  logic        w_batt_low;
  logic [14:0] r_pz_cnt;
  logic        r_piezo;
  logic        w_unused;

  // Assertion is immediate, release is synchronised to clk
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  segway_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
    .i_clk     (clk),
    .i_rst_n   (w_rst_n),
    .i_rx      (RX),
    .i_clr_rdy (w_clr_rx_rdy),
    .o_rdy     (w_rx_rdy),
    .o_data    (w_rx_data)
  );

  // Every byte is consumed the cycle it is presented, whether it acts or not
  assign w_clr_rx_rdy = w_rx_rdy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AUTH_OFF:
        if (w_rx_rdy && w_rx_data == CMD_GO) w_state_nxt = AUTH_PWR1;
      AUTH_PWR1:
        if (w_rx_rdy && w_rx_data == CMD_STOP)
          w_state_nxt = w_rider_off ? AUTH_OFF : AUTH_PWR2;
      AUTH_PWR2:
        if (w_rx_rdy && w_rx_data == CMD_GO) w_state_nxt = AUTH_PWR1;
        else if (w_rider_off)                w_state_nxt = AUTH_OFF;
      default:
        w_state_nxt = AUTH_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= AUTH_OFF;
      r_pwr_up <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pwr_up <= (r_state != AUTH_OFF);
    end
  end

  assign w_poll_tick = (r_poll_cnt & POLL_MASK) == POLL_MASK;
  assign w_ch        = ch_of_idx(r_ch_idx);

  // SCLK period is 32 clocks: fall at phase 15 (MOSI update), rise at 31 (MISO sample)
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_poll_cnt <= '0;
      r_pst      <= P_IDLE;
      r_ph       <= '0;
      r_bit      <= '0;
      r_txn      <= 1'b0;
      r_ch_idx   <= '0;
      r_ss_n     <= 1'b1;
      r_sclk     <= 1'b1;
      r_mosi     <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_lft      <= '0;
      r_rght     <= '0;
      r_batt     <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 16'd1;
      case (r_pst)
        P_IDLE: begin
          if (w_poll_tick) begin
            r_ss_n <= 1'b0;
            r_tx   <= a2d_cmd(w_ch);
            r_ph   <= '0;
            r_bit  <= '0;
            r_pst  <= P_XFER;
          end
        end
        P_XFER: begin
          r_ph <= r_ph + 5'd1;
          if (r_ph == 5'd15) begin
            r_sclk <= 1'b0;
            r_mosi <= r_tx[15];
            r_tx   <= {r_tx[14:0], 1'b0};
          end else if (r_ph == 5'd31) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[14:0], A2D_MISO};
            r_bit  <= r_bit + 4'd1;
            if (r_bit == 4'd15) r_pst <= P_HOLD;
          end
        end
        P_HOLD: begin
          r_ph <= r_ph + 5'd1;
          if (r_ph == 5'd15) begin
            r_ss_n <= 1'b1;
            r_mosi <= 1'b0;
            r_ph   <= '0;
            r_pst  <= P_GAP;
          end
        end
        P_GAP: begin
          r_ph <= r_ph + 5'd1;
          if (r_ph == 5'd15) begin
            r_ph <= '0;
            if (!r_txn) begin
              // First frame only selects the channel; the second returns its result
              r_txn  <= 1'b1;
              r_ss_n <= 1'b0;
              r_tx   <= a2d_cmd(w_ch);
              r_bit  <= '0;
              r_pst  <= P_XFER;
            end else begin
              r_txn <= 1'b0;
              case (r_ch_idx)
                2'd0:    r_lft  <= r_rx[11:0];
                2'd1:    r_rght <= r_rx[11:0];
                default: r_batt <= r_rx[11:0];
              endcase
              r_ch_idx <= (r_ch_idx == 2'd2) ? 2'd0 : r_ch_idx + 2'd1;
              r_pst    <= P_IDLE;
            end
          end
        end
        default: r_pst <= P_IDLE;
      endcase
    end
  end

  assign w_load_sum  = {1'b0, r_lft} + {1'b0, r_rght};
  assign w_rider_off = w_load_sum < {1'b0, MIN_RIDER_WT};
  assign w_batt_low  = r_batt < BATT_LOW;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pz_cnt <= '0;
      r_piezo  <= 1'b0;
    end else begin
      r_pz_cnt <= r_pz_cnt + 15'd1;
      r_piezo  <= (r_pwr_up && w_batt_low) ? r_pz_cnt[14] : 1'b0;
    end
  end

  assign A2D_SS_n   = r_ss_n;
  assign A2D_SCLK   = r_sclk;
  assign A2D_MOSI   = r_mosi;

  assign INERT_SS_n = 1'b1;
  assign INERT_SCLK = 1'b1;
  assign INERT_MOSI = 1'b0;

  assign PWM_frwrd_lft  = 1'b0;
  assign PWM_rev_lft    = 1'b0;
  assign PWM_frwrd_rght = 1'b0;
  assign PWM_rev_rght   = 1'b0;

  assign piezo   = r_piezo;
  assign piezo_n = ~r_piezo;
  assign LED     = {r_pwr_up, w_rider_off, r_batt[11:6]};

  assign w_unused = &{1'b0, INERT_MISO, INT, r_rx[15:12]};

endmodule

// File: tb/tb_segway.sv
// tb/tb_segway.sv - directed bench for segway with an ADC128S SPI slave model
module tb_segway;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       RST_n = 1'b0;
  logic       RX = 1'b1;
  logic       A2D_MISO = 1'b0;
  logic       INERT_MISO = 1'b0;
  logic       INT = 1'b0;
  logic       A2D_SS_n, A2D_SCLK, A2D_MOSI;
  logic       INERT_SS_n, INERT_SCLK, INERT_MOSI;
  logic       PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght;
  logic       piezo, piezo_n;
  logic [7:0] LED;

  logic [11:0] lft_set  = 12'h000;
  logic [11:0] rght_set = 12'h000;
  logic [11:0] batt_set = 12'hC00;
  logic [2:0]  prev_ch  = 3'd0;
  logic [15:0] s_tx     = 16'h0000;
  logic [15:0] s_rx     = 16'h0000;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  segway #(
    .BAUD_DIV     (BAUD),
    .MIN_RIDER_WT (12'h200),
    .BATT_LOW     (12'h800),
    .FAST_SIM     (1)
  ) dut (
    .clk            (clk),
    .RST_n          (RST_n),
    .RX             (RX),
    .A2D_SS_n       (A2D_SS_n),
    .A2D_SCLK       (A2D_SCLK),
    .A2D_MOSI       (A2D_MOSI),
    .A2D_MISO       (A2D_MISO),
    .INERT_SS_n     (INERT_SS_n),
    .INERT_SCLK     (INERT_SCLK),
    .INERT_MOSI     (INERT_MOSI),
    .INERT_MISO     (INERT_MISO),
    .INT            (INT),
    .PWM_frwrd_lft  (PWM_frwrd_lft),
    .PWM_rev_lft    (PWM_rev_lft),
    .PWM_frwrd_rght (PWM_frwrd_rght),
    .PWM_rev_rght   (PWM_rev_rght),
    .piezo          (piezo),
    .piezo_n        (piezo_n),
    .LED            (LED)
  );

  // ADC128S: each frame returns the channel addressed by the previous frame
  always @(negedge A2D_SS_n) begin
    case (prev_ch)
      3'd0:    s_tx = {4'h0, lft_set};
      3'd4:    s_tx = {4'h0, rght_set};
      3'd5:    s_tx = {4'h0, batt_set};
      default: s_tx = 16'h0000;
    endcase
  end
  always @(negedge A2D_SCLK) if (!A2D_SS_n) begin
    A2D_MISO = s_tx[15];
    s_tx = {s_tx[14:0], 1'b0};
  end
  always @(posedge A2D_SCLK) if (!A2D_SS_n) s_rx = {s_rx[14:0], A2D_MOSI};
  always @(posedge A2D_SS_n) prev_ch = s_rx[13:11];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic wait_led(input string tag, input logic [7:0] mask, input logic [7:0] val,
                          input int budget);
    for (int i = 0; i < budget && (LED & mask) != val; i++) @(negedge clk);
    check(tag, LED & mask, val);
  endtask

  task automatic hold_pwr(input string tag, input logic exp);
    repeat (100) @(negedge clk);
    check(tag, LED[7], exp);
  endtask

  initial begin
    logic seen0, seen1;
    int   bad;

    repeat (5) @(negedge clk);
    RST_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_led", LED, 8'h40);
    check("rst_ss", A2D_SS_n, 1'b1);
    check("rst_piezo", {piezo, piezo_n}, 2'b01);
    check("rst_pwm", {PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght}, 4'h0);
    check("rst_inert", {INERT_SS_n, INERT_SCLK, INERT_MOSI}, 3'b110);

    send_byte(8'h67);  wait_led("go_off_to_pwr1", 8'h80, 8'h80, 100);
    send_byte(8'h73);  wait_led("stop_rider_off", 8'h80, 8'h00, 100);
    send_byte(8'h73);  hold_pwr("stop_in_off", 1'b0);
    send_byte(8'h66);  hold_pwr("bad_cmd_in_off", 1'b0);
    send_byte(8'h67);  wait_led("go_again", 8'h80, 8'h80, 100);

    lft_set = 12'h300; rght_set = 12'h300;
    wait_led("rider_on_led", 8'hFF, 8'hB0, 10000);
    send_byte(8'h67);  hold_pwr("go_in_pwr1", 1'b1);
    send_byte(8'h73);  hold_pwr("stop_rider_on", 1'b1);

    lft_set = 12'h000; rght_set = 12'h000;
    wait_led("rider_left_off", 8'hC0, 8'h40, 10000);

    send_byte(8'h67);  wait_led("go_for_alarm", 8'h80, 8'h80, 100);
    batt_set = 12'h700;
    wait_led("batt_low_led", 8'hFF, 8'hDC, 10000);
    seen0 = 1'b0; seen1 = 1'b0; bad = 0;
    for (int i = 0; i < 35000 && !(seen0 && seen1); i++) begin
      @(negedge clk);
      if (piezo) seen1 = 1'b1; else seen0 = 1'b1;
      if (piezo_n !== ~piezo) bad++;
    end
    check("piezo_toggles", {seen0, seen1}, 2'b11);
    check("piezo_diff", bad, 0);

    batt_set = 12'hC00;
    wait_led("batt_ok_led", 8'hFF, 8'hF0, 10000);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (piezo !== 1'b0 || piezo_n !== 1'b1) bad++;
    end
    check("piezo_quiet", bad, 0);

    for (int i = 0; i < 5000 && !A2D_SS_n; i++) @(negedge clk);
    for (int i = 0; i < 5000 && A2D_SS_n; i++) @(negedge clk);
    check("spi_active", A2D_SS_n, 1'b0);
    RX = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    RST_n = 1'b0;
    #1;
    check("mid_rst_led", LED, 8'h40);
    check("mid_rst_ss", A2D_SS_n, 1'b1);
    check("mid_rst_pwm", {PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght}, 4'h0);
    check("mid_rst_piezo", {piezo, piezo_n}, 2'b01);
    RX = 1'b1;
    repeat (4) @(negedge clk);
    RST_n = 1'b1;
    repeat (12 * BAUD) @(negedge clk);
    check("post_rst_idle", LED[7], 1'b0);
    send_byte(8'h67);  wait_led("post_rst_go", 8'h80, 8'h80, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
